if_fetch_unit: RTL

//  Instruction-fetch stage of the toyMIPS pipeline. Owns the PC and drives the instruction memory port
//  (address, write enable, write data); latches the returned word into the IF/ID pipeline register for decode.

---
 rtl/if_fetch_unit_if.sv | 32 +++
 rtl/if_fetch_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - load stream, instruction-memory port and IF/ID bundle for the fetch stage
interface if_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              ld_start;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              ld_last;
  logic              run;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] im_addr;
  logic              im_wr;
  logic [31:0]       im_wd;
  logic [31:0]       im_rdata;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic              ifid_valid;
  logic              halted;

  // master is the fetch unit itself; slave is the surrounding pipeline/memory/loader
  modport master (
    input  ld_start, ld_valid, ld_data, ld_last, run, stall, redirect, redirect_pc, im_rdata,
    output ld_ready, im_addr, im_wr, im_wd, ifid_instr, ifid_pc, ifid_valid, halted
  );
  modport slave (
    output ld_start, ld_valid, ld_data, ld_last, run, stall, redirect, redirect_pc, im_rdata,
    input  ld_ready, im_addr, im_wr, im_wd, ifid_instr, ifid_pc, ifid_valid, halted
  );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - toyMIPS instruction fetch: PC, IF/ID register and instruction-memory loader
module if_fetch_unit #(
  parameter int          ADDR_W     = 8,
  parameter int          IM_DEPTH   = 8,
  parameter int          RESET_PC   = 0,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  if_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH, S_HALT} state_t;

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LAST_IX = ADDR_W'(IM_DEPTH - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ifid_instr_q;
  logic [ADDR_W-1:0] ifid_pc_q;
  logic              ifid_valid_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ld_addr_d;

  assign pc_d      = (pc_q == LAST_IX) ? '0 : pc_q + 1'b1;
  assign ld_addr_d = (ld_addr_q == LAST_IX) ? '0 : ld_addr_q + 1'b1;

  // The loader owns the memory port only while in LOAD; otherwise the port reads at the PC.
  assign bus.ld_ready   = (state_q == S_LOAD);
  assign bus.im_wr      = (state_q == S_LOAD) && bus.ld_valid;
  assign bus.im_wd      = (state_q == S_LOAD) ? bus.ld_data : 32'h0;
  assign bus.im_addr    = (state_q == S_LOAD) ? ld_addr_q : pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RST;
      ld_addr_q    <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.ld_start)  state_q <= S_LOAD;
          else if (bus.run)  state_q <= S_FETCH;
        end
        S_LOAD: begin
          if (bus.ld_valid) begin
            if (bus.ld_last) begin
              state_q   <= S_IDLE;
              ld_addr_q <= '0;
              pc_q      <= PC_RST;
            end else begin
              ld_addr_q <= ld_addr_d;
            end
          end
        end
        S_FETCH: begin
          if (bus.redirect) begin
            pc_q         <= bus.redirect_pc;
            ifid_valid_q <= 1'b0;
          end else if (!bus.stall) begin
            ifid_instr_q <= bus.im_rdata;
            ifid_pc_q    <= pc_q;
            ifid_valid_q <= 1'b1;
            // The halt word is delivered to decode but the PC stays pointing at it.
            if (bus.im_rdata == HALT_INSTR) state_q <= S_HALT;
            else                            pc_q    <= pc_d;
          end
        end
        S_HALT: begin
          if (bus.redirect) begin
            state_q      <= S_FETCH;
            pc_q         <= bus.redirect_pc;
            ifid_valid_q <= 1'b0;
          end else begin
            if (!bus.stall)   ifid_valid_q <= 1'b0;
            if (bus.ld_start) state_q      <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
